// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard inputs and stall/flush/status outputs of the stall controller.
interface pipe_stall_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW = 4,
  parameter int CNT_W = 16
);
  logic i_hit;
  logic d_hit;
  logic mem_op;
  logic accel_stall;
  logic mem_re_ex;
  logic mem_we_id;
  logic [REG_AW-1:0] dst_addr;
  logic [REG_AW-1:0] p0_addr;
  logic [REG_AW-1:0] p1_addr;
  logic p0_vld;
  logic p1_vld;
  logic send;
  logic full;
  logic [1:0] cnt_sel;
  logic cnt_clr;
  logic [NUM_STAGES-1:0] stall;
  logic idex_flush;
  logic [CNT_W-1:0] cnt_out;
  logic stall_timeout;
  modport master (
    output i_hit, d_hit, mem_op, accel_stall, mem_re_ex, mem_we_id,
    output dst_addr, p0_addr, p1_addr, p0_vld, p1_vld, send, full, cnt_sel, cnt_clr,
    input  stall, idex_flush, cnt_out, stall_timeout
  );
  modport slave (
    input  i_hit, d_hit, mem_op, accel_stall, mem_re_ex, mem_we_id,
    input  dst_addr, p0_addr, p1_addr, p0_vld, p1_vld, send, full, cnt_sel, cnt_clr,
    output stall, idex_flush, cnt_out, stall_timeout
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: prioritises hazard causes into per-stage stall/flush, with multi-cycle
// load-use bubbles, per-cause saturating stall counters and a full-freeze watchdog.
module pipe_stall_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int ID_IDX = 2,
  parameter int REG_AW = 4,
  parameter int LOAD_LAT = 1,
  parameter int STORE_FWD = 1,
  parameter int CNT_W = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input logic clk,
  input logic rst_n,
  pipe_stall_ctrl_if.slave bus
);
  typedef enum logic [2:0] {C_NONE, C_IMISS, C_DMISS, C_LU, C_SPART} cause_t;
  localparam int FW = $clog2(WDOG_CYCLES + 1);
  localparam logic [NUM_STAGES-1:0] LU_MASK = NUM_STAGES'((1 << ID_IDX) - 1);
  localparam logic [NUM_STAGES-1:0] SP_MASK = NUM_STAGES'((1 << (ID_IDX + 1)) - 1);
  localparam logic [3:0] LU_INIT = 4'(LOAD_LAT - 1);
  localparam logic [FW-1:0] WD_MAX = FW'(WDOG_CYCLES);
  localparam logic [FW-1:0] WD_LAST = FW'(WDOG_CYCLES - 1);
  cause_t cause;
  logic [3:0] lu_cnt, lu_cnt_nxt;
  logic lu_hz, lu_act, frz;
  logic [3:0] inc;
  logic [CNT_W-1:0] cnt [4];
  logic [FW-1:0] frz_cnt;
  logic timeout;
  always_comb begin
    lu_hz = lu_cnt == 4'd0 && bus.mem_re_ex && !(STORE_FWD != 0 && bus.mem_we_id) &&
            ((bus.p0_vld && bus.dst_addr == bus.p0_addr) || (bus.p1_vld && bus.dst_addr == bus.p1_addr));
    lu_act = lu_hz || lu_cnt != 4'd0;
    cause = !bus.i_hit ? C_IMISS :
            ((bus.mem_op && !bus.d_hit) || bus.accel_stall) ? C_DMISS :
            lu_act ? C_LU :
            (bus.send && bus.full) ? C_SPART : C_NONE;
    // a miss leaves the bubble count untouched so the sequence resumes afterwards
    lu_cnt_nxt = cause != C_LU ? lu_cnt : lu_cnt == 4'd0 ? LU_INIT : lu_cnt - 4'd1;
    inc = {cause == C_SPART, cause == C_LU, cause == C_DMISS, cause == C_IMISS};
    frz = bus.stall[NUM_STAGES-1];
  end
  assign bus.stall = (cause == C_IMISS || cause == C_DMISS) ? {NUM_STAGES{1'b1}} :
                     cause == C_LU ? LU_MASK :
                     cause == C_SPART ? SP_MASK : {NUM_STAGES{1'b0}};
  assign bus.idex_flush = cause == C_LU;
  assign bus.cnt_out = cnt[bus.cnt_sel];
  assign bus.stall_timeout = timeout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lu_cnt <= 4'd0;
    else lu_cnt <= lu_cnt_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 4; i++) cnt[i] <= '0;
    else for (int i = 0; i < 4; i++)
      cnt[i] <= bus.cnt_clr ? '0 : (inc[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frz_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      frz_cnt <= !frz ? '0 : frz_cnt == WD_MAX ? frz_cnt : frz_cnt + 1'b1;
      timeout <= !bus.cnt_clr && (timeout || (frz && frz_cnt == WD_LAST));
    end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor
// across three parameterisations (LOAD_LAT=3/WDOG=8, defaults, STORE_FWD=0).
module tb_pipe_stall_ctrl;
  typedef struct packed {
    logic i_hit, d_hit, mem_op, accel_stall, mem_re_ex, mem_we_id;
    logic [3:0] dst_addr, p0_addr, p1_addr;
    logic p0_vld, p1_vld, send, full;
    logic [1:0] cnt_sel;
    logic cnt_clr;
  } drv_t;
  typedef struct {
    int dut;
    string nm;
    logic [4:0] st;
    logic fl;
    int cn;
    int to;
  } exp_t;
  logic clk, rst_n;
  drv_t d;
  exp_t q[$];
  exp_t m;
  int checks = 0, failures = 0;
  logic [4:0] mst;
  logic mfl, mto;
  logic [15:0] mcn;
  pipe_stall_ctrl_if ifa(), ifb(), ifc();
  assign {ifa.i_hit, ifa.d_hit, ifa.mem_op, ifa.accel_stall, ifa.mem_re_ex, ifa.mem_we_id, ifa.dst_addr, ifa.p0_addr, ifa.p1_addr, ifa.p0_vld, ifa.p1_vld, ifa.send, ifa.full, ifa.cnt_sel, ifa.cnt_clr} = d;
  assign {ifb.i_hit, ifb.d_hit, ifb.mem_op, ifb.accel_stall, ifb.mem_re_ex, ifb.mem_we_id, ifb.dst_addr, ifb.p0_addr, ifb.p1_addr, ifb.p0_vld, ifb.p1_vld, ifb.send, ifb.full, ifb.cnt_sel, ifb.cnt_clr} = d;
  assign {ifc.i_hit, ifc.d_hit, ifc.mem_op, ifc.accel_stall, ifc.mem_re_ex, ifc.mem_we_id, ifc.dst_addr, ifc.p0_addr, ifc.p1_addr, ifc.p0_vld, ifc.p1_vld, ifc.send, ifc.full, ifc.cnt_sel, ifc.cnt_clr} = d;
  pipe_stall_ctrl #(.LOAD_LAT(3), .WDOG_CYCLES(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  pipe_stall_ctrl dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  pipe_stall_ctrl #(.STORE_FWD(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic drv_t idle();
    drv_t v = '0;
    v.i_hit = 1'b1;
    v.d_hit = 1'b1;
    return v;
  endfunction
  function automatic drv_t idle_sel(input logic [1:0] s);
    drv_t v = idle();
    v.cnt_sel = s;
    return v;
  endfunction
  function automatic drv_t hz();
    drv_t v = idle();
    v.mem_re_ex = 1'b1;
    v.dst_addr = 4'd4;
    v.p1_addr = 4'd4;
    v.p1_vld = 1'b1;
    return v;
  endfunction
  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask
  task automatic expect_out(input string nm, input int dut, input logic [4:0] es, input logic ef, input int ec, input int et);
    exp_t e;
    e.dut = dut;
    e.nm = nm;
    e.st = es;
    e.fl = ef;
    e.cn = ec;
    e.to = et;
    q.push_back(e);
  endtask
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input string nm, input int dut, input drv_t v, input logic [4:0] es, input logic ef, input int ec, input int et);
    d = v;
    expect_out(nm, dut, es, ef, ec, et);
    go();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    d = idle();
    go();
    rst_n = 1'b1;
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin
      m = q.pop_front();
      mst = m.dut == 0 ? ifa.stall : m.dut == 1 ? ifb.stall : ifc.stall;
      mfl = m.dut == 0 ? ifa.idex_flush : m.dut == 1 ? ifb.idex_flush : ifc.idex_flush;
      mcn = m.dut == 0 ? ifa.cnt_out : m.dut == 1 ? ifb.cnt_out : ifc.cnt_out;
      mto = m.dut == 0 ? ifa.stall_timeout : m.dut == 1 ? ifb.stall_timeout : ifc.stall_timeout;
      check({m.nm, ".stall"}, int'(mst), int'(m.st));
      check({m.nm, ".flush"}, int'(mfl), int'(m.fl));
      if (m.cn >= 0) check({m.nm, ".cnt"}, int'(mcn), m.cn);
      if (m.to >= 0) check({m.nm, ".timeout"}, int'(mto), m.to);
    end
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end
  initial begin
    drv_t v;
    rst_n = 1'b0;
    d = idle();
    #6;
    // reset state: outputs follow inputs with zeroed state
    v = hz();
    v.i_hit = 1'b0;
    d = v;
    expect_out("rst_imiss_a", 0, 5'b11111, 1'b0, 0, 0);
    expect_out("rst_imiss_b", 1, 5'b11111, 1'b0, 0, 0);
    go();
    cyc("rst_idle_a", 0, idle(), 5'b00000, 1'b0, 0, 0);
    rst_n = 1'b1;
    // defaults: imiss wins over load-use, then single bubble
    cyc("b_imiss", 1, v, 5'b11111, 1'b0, -1, -1);
    cyc("b_lu", 1, hz(), 5'b00011, 1'b1, -1, -1);
    cyc("b_after", 1, idle(), 5'b00000, 1'b0, -1, -1);
    // LOAD_LAT=3: exactly three bubbles from one hazard cycle
    do_reset();
    cyc("a_lu1", 0, hz(), 5'b00011, 1'b1, -1, -1);
    cyc("a_lu2", 0, idle(), 5'b00011, 1'b1, -1, -1);
    cyc("a_lu3", 0, idle(), 5'b00011, 1'b1, -1, -1);
    cyc("a_lu_end", 0, idle_sel(2), 5'b00000, 1'b0, 3, -1);
    cyc("a_lu_hold", 0, idle_sel(2), 5'b00000, 1'b0, 3, -1);
    // dmiss interleaved into the bubble sequence
    do_reset();
    cyc("a_i_lu1", 0, hz(), 5'b00011, 1'b1, -1, -1);
    v = idle();
    v.mem_op = 1'b1;
    v.d_hit = 1'b0;
    cyc("a_dm1", 0, v, 5'b11111, 1'b0, -1, -1);
    cyc("a_dm2", 0, v, 5'b11111, 1'b0, -1, -1);
    cyc("a_i_lu2", 0, idle(), 5'b00011, 1'b1, -1, -1);
    cyc("a_i_lu3", 0, idle(), 5'b00011, 1'b1, -1, -1);
    cyc("a_i_lu_cnt", 0, idle_sel(2), 5'b00000, 1'b0, 3, -1);
    cyc("a_i_dm_cnt", 0, idle_sel(1), 5'b00000, 1'b0, 2, -1);
    // source-valid and store-forward qualification
    do_reset();
    v = idle();
    v.mem_re_ex = 1'b1;
    v.dst_addr = 4'd4;
    v.p0_addr = 4'd4;
    d = v;
    expect_out("q_novld_b", 1, 5'b00000, 1'b0, -1, -1);
    expect_out("q_novld_c", 2, 5'b00000, 1'b0, -1, -1);
    go();
    v.p0_vld = 1'b1;
    v.mem_we_id = 1'b1;
    d = v;
    expect_out("q_store_fwd_b", 1, 5'b00000, 1'b0, -1, -1);
    expect_out("q_store_nofwd_c", 2, 5'b00011, 1'b1, -1, -1);
    go();
    v.mem_we_id = 1'b0;
    cyc("q_p0_b", 1, v, 5'b00011, 1'b1, -1, -1);
    v.p0_vld = 1'b0;
    v.p1_vld = 1'b1;
    v.p1_addr = 4'd5;
    cyc("q_p1_miss_b", 1, v, 5'b00000, 1'b0, -1, -1);
    v.p1_addr = 4'd4;
    v.mem_re_ex = 1'b0;
    cyc("q_noload_b", 1, v, 5'b00000, 1'b0, -1, -1);
    // SPART back-pressure, counter clear and priority
    do_reset();
    v = idle();
    v.send = 1'b1;
    v.full = 1'b1;
    for (int i = 0; i < 4; i++) cyc("a_sp", 0, v, 5'b00111, 1'b0, -1, -1);
    cyc("a_sp_cnt", 0, idle_sel(3), 5'b00000, 1'b0, 4, -1);
    v = idle_sel(3);
    v.cnt_clr = 1'b1;
    cyc("a_clr_pre", 0, v, 5'b00000, 1'b0, 4, -1);
    cyc("a_clr", 0, idle_sel(3), 5'b00000, 1'b0, 0, -1);
    v.send = 1'b1;
    v.full = 1'b1;
    cyc("a_clr_sp", 0, v, 5'b00111, 1'b0, 0, -1);
    cyc("a_clr_sp_cnt", 0, idle_sel(3), 5'b00000, 1'b0, 0, -1);
    v = idle();
    v.i_hit = 1'b0;
    v.accel_stall = 1'b1;
    v.send = 1'b1;
    v.full = 1'b1;
    cyc("a_imiss_pri", 0, v, 5'b11111, 1'b0, -1, -1);
    cyc("a_imiss_cnt", 0, idle_sel(0), 5'b00000, 1'b0, 1, -1);
    cyc("a_dmiss_cnt0", 0, idle_sel(1), 5'b00000, 1'b0, 0, -1);
    v = hz();
    v.send = 1'b1;
    v.full = 1'b1;
    cyc("a_lu_pri", 0, v, 5'b00011, 1'b1, -1, -1);
    cyc("a_lu_pri2", 0, idle(), 5'b00011, 1'b1, -1, -1);
    cyc("a_lu_pri3", 0, idle(), 5'b00011, 1'b1, -1, -1);
    cyc("a_sp_cnt0", 0, idle_sel(3), 5'b00000, 1'b0, 0, -1);
    cyc("a_lu_cnt3", 0, idle_sel(2), 5'b00000, 1'b0, 3, -1);
    // watchdog: 7 frozen cycles stay quiet, 8 set the sticky flag
    do_reset();
    v = idle();
    v.accel_stall = 1'b1;
    for (int i = 0; i < 7; i++) cyc("a_wd7", 0, v, 5'b11111, 1'b0, -1, 0);
    cyc("a_wd7_rel", 0, idle(), 5'b00000, 1'b0, -1, 0);
    cyc("a_wd7_low", 0, idle(), 5'b00000, 1'b0, -1, 0);
    for (int i = 0; i < 8; i++) cyc("a_wd8", 0, v, 5'b11111, 1'b0, -1, 0);
    cyc("a_wd_set", 0, idle_sel(1), 5'b00000, 1'b0, 15, 1);
    cyc("a_wd_sticky", 0, idle(), 5'b00000, 1'b0, -1, 1);
    v = idle();
    v.cnt_clr = 1'b1;
    cyc("a_wd_clrcyc", 0, v, 5'b00000, 1'b0, -1, 1);
    cyc("a_wd_clr", 0, idle(), 5'b00000, 1'b0, -1, 0);
    // reset in the middle of a bubble sequence
    do_reset();
    cyc("a_mb_lu", 0, hz(), 5'b00011, 1'b1, -1, -1);
    rst_n = 1'b0;
    cyc("a_mb_rst", 0, idle_sel(2), 5'b00000, 1'b0, 0, 0);
    rst_n = 1'b1;
    cyc("a_mb_after", 0, idle_sel(2), 5'b00000, 1'b0, 0, -1);
    go();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Parametrised pipeline stall/flush controller for the processor core. It prioritises the hazard sources (I-cache miss, D-cache miss, accelerator, load-use, SPART TX back-pressure) into per-stage stall and flush vectors. It adds multi-cycle load-use bubbles, source-valid qualification, per-cause saturating stall counters and a freeze watchdog. It sits beside the pipeline registers; every pipeline register takes one `stall` bit, and the ID/EX register also takes `idex_flush`.

## Interface
- `NUM_STAGES`, default 5: number of pipeline registers, PC included; index 0 = PC, ascending toward WB; minimum 4.
- `ID_IDX`, default 2: index of the ID/EX register; range 2..NUM_STAGES-2.
- `REG_AW`, default 4: register address width.
- `LOAD_LAT`, default 1: bubbles per load-use hazard; range 1..15.
- `STORE_FWD`, default 1: 1 = a store in ID never triggers a load-use stall, because its data is forwarded in MEM.
- `CNT_W`, default 16: width of each stall counter.
- `WDOG_CYCLES`, default 1024: limit on consecutive full-freeze cycles.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_hit` in 1: instruction fetch hit.
- `d_hit` in 1: data access hit.
- `mem_op` in 1: memory access in MEM.
- `accel_stall` in 1: accelerator requests a global freeze.
- `mem_re_ex` in 1: load in EX.
- `mem_we_id` in 1: store in ID.
- `dst_addr` in REG_AW: destination of the EX load.
- `p0_addr`, `p1_addr` in REG_AW: ID source registers.
- `p0_vld`, `p1_vld` in 1: the ID instruction actually reads p0 / p1.
- `send` in 1: SPART transmit in EX.
- `full` in 1: SPART TX queue full.
- `cnt_sel` in 2: counter select: 0 imiss, 1 dmiss/accel, 2 load-use, 3 spart.
- `cnt_clr` in 1: synchronous clear of all counters and the timeout flag.
- `stall` out NUM_STAGES: per-register hold.
- `idex_flush` out 1: insert a bubble into ID/EX.
- `cnt_out` out CNT_W: selected counter.
- `stall_timeout` out 1: sticky watchdog flag.

## Operation
- Cause selection, in priority order; `stall`/`idex_flush` are combinational from the inputs and the registered state:
  1. `~i_hit`, cause IMISS: `stall` all ones, no flush.
  2. `(mem_op & ~d_hit) | accel_stall`, cause DMISS: all ones, no flush.
  3. Load-use active (`lu_hz | lu_cnt != 0`), cause LU: `stall[ID_IDX-1:0]` = 1, `idex_flush` = 1, other stall bits 0.
  4. `send & full`, cause SPART: `stall[ID_IDX:0]` = 1, others 0, no flush.
  5. Otherwise: all 0.
- Load-use detection:
  - `lu_hz = mem_re_ex & ~(STORE_FWD & mem_we_id) & ((p0_vld & dst_addr==p0_addr) | (p1_vld & dst_addr==p1_addr))`.
  - `lu_hz` is evaluated only when `lu_cnt` = 0.
- `lu_cnt`, 4-bit state register:
  - Loads LOAD_LAT-1 on a cycle where cause LU is selected by `lu_hz` with `lu_cnt` = 0.
  - Decrements on each cycle where cause LU is selected with `lu_cnt` != 0.
  - Holds unchanged while IMISS or DMISS is selected; a miss freezes the bubble sequence.
  - With LOAD_LAT = 1 the counter never leaves 0, which reproduces the single-bubble behaviour.
- Counters:
  - Four CNT_W counters; each increments on every cycle its cause is the selected one.
  - They saturate at all ones.
  - `cnt_clr` zeroes all four and has priority over increment.
  - `cnt_out` = counter[`cnt_sel`], combinational.
- Watchdog:
  - `frz_cnt` counts consecutive cycles with `stall[NUM_STAGES-1]` = 1; it clears on any cycle where that bit is 0.
  - When `frz_cnt` reaches WDOG_CYCLES, `stall_timeout` sets and stays set until `cnt_clr` or reset.
  - `frz_cnt` saturates at WDOG_CYCLES.
  - Stalls are not altered by the timeout; it is a status flag only.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `lu_cnt`, all counters, `frz_cnt` and `stall_timeout` go to 0.
  - `stall` and `idex_flush` then follow the current inputs combinationally with state 0.
  - `cnt_out` reads 0.
- Zero-latency decode: a hazard visible in cycle N stalls cycle N's clock edge.
- A load-use hazard occupies exactly LOAD_LAT cycles of cause LU, plus any interleaved miss cycles.
- Counters and the watchdog update on the rising edge following the qualifying cycle; `cnt_out` reflects the increment one cycle later.
- Reset mid-bubble aborts the sequence: `lu_cnt` goes to 0 and the pipeline is responsible for its own state.
- Simultaneous `cnt_clr` and a qualifying cause: the result is 0, and the cause cycle is not counted.
- `stall_timeout` asserts on the edge where `frz_cnt` goes from WDOG_CYCLES-1 to WDOG_CYCLES, i.e. after WDOG_CYCLES consecutive frozen cycles.

## Test plan
- Defaults; `i_hit`=0 with `mem_re_ex`=1 and a hazard present -> `stall`=5'b11111, `idex_flush`=0; `i_hit`=1 next cycle -> load-use response: `stall`=5'b00011, flush=1.
- LOAD_LAT=3; `dst_addr`=4, `p1_addr`=4, `p1_vld`=1, `mem_re_ex` for 1 cycle -> exactly 3 cycles of `stall`=00011 with flush=1; LU counter = 3.
- Same as above with `d_hit`=0 and `mem_op`=1 for 2 cycles injected after bubble 1 -> sequence is 1 LU, 2 DMISS (all ones), 2 LU; counters LU=3, DMISS=2.
- `p0_addr` matches `dst_addr` with `p0_vld`=0 -> no stall; with `mem_we_id`=1, STORE_FWD=1 and a valid match -> no stall; with STORE_FWD=0 -> stall.
- `send`=1 and `full`=1 for 4 cycles -> `stall`=5'b00111, no flush, SPART counter = 4; `cnt_clr` -> `cnt_out`=0.
- WDOG_CYCLES=8, `accel_stall` held 8 cycles -> `stall_timeout` rises after the 8th edge and stays high after release; held 7 cycles then released -> flag stays low.
